hazard_stall_ctrl: RTL and testbench



---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/muldiv_busy_counter.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 96 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg
//   Shared constants and the mult/div tracker state encoding for the pipeline.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int          REG_W             = 5;
    localparam logic [4:0]  REG_ZERO          = 5'd0;
    localparam int          MULDIV_CYCLES_DEF = 4;
    localparam int          CNT_W             = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_e;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/muldiv_busy_counter.sv
// ============================================================================
// muldiv_busy_counter
//   Loadable down-counter tracking how long the mult/div unit stays busy.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_busy_counter
    import pipeline_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_CYCLES);

    muldiv_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    cnt_d = LOAD_VAL;
                end
            end
            BUSY: begin
                if (load) begin
                    cnt_d = LOAD_VAL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // State always mirrors whether the counter is non-zero.
        state_d = (cnt_d != '0) ? BUSY : IDLE;
    end

    assign busy = (state_q == BUSY);

endmodule : muldiv_busy_counter

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl
//   Load-use and HI/LO hazard detection driving PC hold, IF/ID hold, ID/EX
//   flush. Optional statistics counters with HAZARD_STALL_STATS_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int REG_W         = pipeline_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_muldiv,
    input  logic             id_hilo_read,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_flush,
    output logic             muldiv_busy
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      load_use_cnt
`endif
);

    logic load_use;
    logic hilo_stall;
    logic stall;
    logic issue;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read
                    & (ex_rt != REG_W'(REG_ZERO))
                    & ((id_use_rs & (id_rs == ex_rt)) |
                       (id_use_rt & (id_rt == ex_rt)));

    assign hilo_stall = muldiv_busy & (id_hilo_read | id_muldiv);
    assign stall      = load_use | hilo_stall;
    assign issue      = id_muldiv & ~stall;

    assign pc_hold    = stall;
    assign ifid_hold  = stall;
    assign idex_flush = stall;

    muldiv_busy_counter #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_busy_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (issue),
        .busy  (muldiv_busy)
    );

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] load_use_cnt_q, load_use_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            load_use_cnt_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        load_use_cnt_d = load_use_cnt_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (load_use && (load_use_cnt_q != '1)) begin
            load_use_cnt_d = load_use_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign load_use_cnt = load_use_cnt_q;
`endif

endmodule : hazard_stall_ctrl

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// tb_hazard_stall_ctrl
//   Directed self-checking bench for hazard_stall_ctrl (MULDIV_CYCLES = 4).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, ex_mem_read, id_muldiv, id_hilo_read;
    logic       pc_hold, ifid_hold, idex_flush, muldiv_busy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] load_use_cnt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string tag;
        logic  stall;
        logic  busy;
    } exp_t;

    exp_t sb[$];

    hazard_stall_ctrl #(
        .MULDIV_CYCLES (MC),
        .REG_W         (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .id_muldiv    (id_muldiv),
        .id_hilo_read (id_hilo_read),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_flush   (idex_flush),
        .muldiv_busy  (muldiv_busy)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .load_use_cnt (load_use_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic b);
        exp_t e;
        e.tag   = tag;
        e.stall = s;
        e.busy  = b;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [3:0] obs;
        logic [3:0] req;
        e   = sb.pop_front();
        obs = {pc_hold, ifid_hold, idex_flush, muldiv_busy};
        req = {e.stall, e.stall, e.stall, e.busy};
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed {pc,ifid,flush,busy}=%b expected=%b", e.tag, obs, req);
        end
    endtask

    task automatic chk(input string tag, input logic s, input logic b);
        expect_out(tag, s, b);
        #1;
        check_out();
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
        id_muldiv = 1'b0; id_hilo_read = 1'b0;
    endtask

    task automatic set_load(input logic rd, input logic [4:0] rt, input logic [4:0] rs,
                            input logic urs);
        ex_mem_read = rd; ex_rt = rt; id_rs = rs; id_use_rs = urs;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset", 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", 1'b0, 1'b0);
        end

        // Load-use via rs, lasting one cycle
        set_load(1'b1, 5'd8, 5'd8, 1'b1);
        chk("load_use_rs", 1'b1, 1'b0);
        step();
        ex_mem_read = 1'b0;
        chk("load_use_one_cycle", 1'b0, 1'b0);
        set_load(1'b1, 5'd0, 5'd0, 1'b1);
        chk("load_use_r0", 1'b0, 1'b0);
        set_load(1'b1, 5'd8, 5'd8, 1'b0);
        chk("load_use_no_rs_use", 1'b0, 1'b0);
        id_rt = 5'd8; id_use_rt = 1'b1;
        chk("load_use_rt", 1'b1, 1'b0);
        id_rt = 5'd9;
        chk("load_use_rt_mismatch", 1'b0, 1'b0);
        step();
        clear_inputs();

        // mult then mfhi held
        id_muldiv = 1'b1;
        chk("mult_issue", 1'b0, 1'b0);
        step();
        id_muldiv = 1'b0; id_hilo_read = 1'b1;
        for (int i = 1; i <= MC; i++) begin
            chk($sformatf("mfhi_wait_%0d", i), 1'b1, 1'b1);
            step();
        end
        chk("mfhi_proceeds", 1'b0, 1'b0);
        step();
        clear_inputs();

        // Back-to-back mult/div
        id_muldiv = 1'b1;
        chk("b2b_first_issue", 1'b0, 1'b0);
        step();
        for (int i = 1; i <= MC; i++) begin
            chk($sformatf("b2b_stall_%0d", i), 1'b1, 1'b1);
            step();
        end
        chk("b2b_second_issue", 1'b0, 1'b0);
        step();
        id_muldiv = 1'b0;
        chk("b2b_reloaded", 1'b0, 1'b1);
        step();

        // Async reset while cnt==3 with a dependent mfhi in ID
        id_hilo_read = 1'b1;
        chk("pre_reset_cnt3", 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        chk("async_reset_mid_busy", 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        clear_inputs();
        step();

        // Load-use together with mult: no issue
        set_load(1'b1, 5'd8, 5'd8, 1'b1);
        id_muldiv = 1'b1;
        chk("lu_and_mult", 1'b1, 1'b0);
        step();
        ex_mem_read = 1'b0;
        chk("mult_not_loaded", 1'b0, 1'b0);
        step();
        clear_inputs();
        chk("mult_issued_late", 1'b0, 1'b1);
        for (int i = 0; i < MC; i++) step();
        chk("drained_idle", 1'b0, 1'b0);

`ifdef HAZARD_STALL_STATS_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        set_load(1'b1, 5'd8, 5'd8, 1'b1);
        for (int i = 0; i < 3; i++) step();
        clear_inputs();
        id_muldiv = 1'b1;
        step();
        id_muldiv = 1'b0; id_hilo_read = 1'b1;
        for (int i = 0; i < MC; i++) step();
        clear_inputs();
        step();
        tests++;
        assert (stall_cycles === 32'd7) else begin
            fails++;
            $error("FAIL stall_cycles: observed=%0d expected=7", stall_cycles);
        end
        tests++;
        assert (load_use_cnt === 16'd3) else begin
            fails++;
            $error("FAIL load_use_cnt: observed=%0d expected=3", load_use_cnt);
        end
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl

`default_nettype wire
